// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_RELEASE
  } sram_arb_state_t;

  // A zero wait count still needs one stable access cycle.
  function automatic int unsigned eff_wait(int unsigned wait_cycles);
    return (wait_cycles < 1) ? 1 : wait_cycles;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin chooser: on a tie the port that was not
// granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one external SRAM between two requesters with a fixed
// address/wait/capture/release schedule and round-robin grants.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = SRAM_ADDR_W,
  parameter int unsigned DATA_W      = SRAM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_wen0,
  input  logic              i_wen1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_sram_en,
  output logic              o_sram_wen,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_busy
);

  localparam int unsigned WAIT_EFF = eff_wait(WAIT_CYCLES);
  localparam int unsigned CNT_W    = $clog2(WAIT_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sram_arb_state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              en_q, en_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;

  logic grant_valid;
  logic grant_idx;

  rr_pick2 u_pick (
    .req         ({i_req1, i_req0}),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only looked at in S_IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (grant_valid) state_d = S_ACCESS;
      S_ACCESS:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:    state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values of every registered output and of the datapath state
  always_comb begin
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    en_d     = en_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    busy_d   = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          gnt_d   = grant_idx;
          last_d  = grant_idx;
          cnt_d   = '0;
          en_d    = 1'b1;
          wen_d   = grant_idx ? i_wen1 : i_wen0;
          addr_d  = grant_idx ? i_addr1 : i_addr0;
          wdata_d = grant_idx ? i_wdata1 : i_wdata0;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + CNT_ONE;
      end
      S_DONE: begin
        if (!wen_q) begin
          if (gnt_q) rdata1_d = i_sram_rdata;
          else       rdata0_d = i_sram_rdata;
        end
        ack0_d = ~gnt_q;
        ack1_d = gnt_q;
        // Enables drop for the release cycle; address and data keep their value.
        en_d   = 1'b0;
        wen_d  = 1'b0;
      end
      S_RELEASE: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      en_q     <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      en_q     <= en_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign o_ack0       = ack0_q;
  assign o_ack1       = ack1_q;
  assign o_rdata0     = rdata0_q;
  assign o_rdata1     = rdata1_q;
  assign o_sram_en    = en_q;
  assign o_sram_wen   = wen_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_wdata = wdata_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus a randomized
// run against a transaction-timing reference model.
module tb_sram_arbiter;

  localparam int WA = 1;  // wait cycles of the main instance
  localparam int WB = 3;  // wait cycles of the second instance

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0, req1, wen0, wen1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1, sram_rdata;
  logic        ack0, ack1, sram_en, sram_wen, busy;
  logic [15:0] rdata0, rdata1, sram_wdata;
  logic [19:0] sram_addr;

  logic        w3_req0, w3_wen0;
  logic [19:0] w3_addr0;
  logic [15:0] w3_wdata0, w3_sram_rdata;
  logic        w3_ack0, w3_ack1, w3_sram_en, w3_sram_wen, w3_busy;
  logic [15:0] w3_rdata0, w3_rdata1, w3_sram_wdata;
  logic [19:0] w3_sram_addr;

  int vectors = 0;
  int miscompares = 0;

  sram_arbiter #(.WAIT_CYCLES(WA), .ADDR_W(20), .DATA_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_wen0(wen0), .i_wen1(wen1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_sram_en(sram_en), .o_sram_wen(sram_wen), .o_sram_addr(sram_addr),
    .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata), .o_busy(busy)
  );

  sram_arbiter #(.WAIT_CYCLES(WB), .ADDR_W(20), .DATA_W(16)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(w3_req0), .i_req1(1'b0), .i_wen0(w3_wen0), .i_wen1(1'b0),
    .i_addr0(w3_addr0), .i_addr1(20'h0), .i_wdata0(w3_wdata0), .i_wdata1(16'h0),
    .o_ack0(w3_ack0), .o_ack1(w3_ack1), .o_rdata0(w3_rdata0), .o_rdata1(w3_rdata1),
    .o_sram_en(w3_sram_en), .o_sram_wen(w3_sram_wen), .o_sram_addr(w3_sram_addr),
    .o_sram_wdata(w3_sram_wdata), .i_sram_rdata(w3_sram_rdata), .o_busy(w3_busy)
  );

  task automatic clear_inputs;
    req0 = 0; req1 = 0; wen0 = 0; wen1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; sram_rdata = '0;
    w3_req0 = 0; w3_wen0 = 0; w3_addr0 = '0; w3_wdata0 = '0; w3_sram_rdata = '0;
  endtask

  // Leaves the caller at cycle 0, just after the first active edge is due.
  task automatic apply_reset;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ack0, ack1, busy} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ack_busy: got %b want 000", {ack0, ack1, busy});
    end
    vectors++;
    if ({sram_en, sram_wen} !== 2'b00) begin
      miscompares++; $display("FAIL reset_enables: got %b want 00", {sram_en, sram_wen});
    end
    vectors++;
    if ({sram_addr, sram_wdata} !== 36'h0) begin
      miscompares++; $display("FAIL reset_addr_wdata: got %h want 0", {sram_addr, sram_wdata});
    end
    vectors++;
    if ({rdata0, rdata1} !== 32'h0) begin
      miscompares++; $display("FAIL reset_rdata: got %h want 0", {rdata0, rdata1});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_no_req_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single_read;
    apply_reset();
    req0 = 1; wen0 = 0; addr0 = 20'h00010; sram_rdata = 16'hBEEF;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (sram_en !== (c <= 2)) begin
        miscompares++; $display("FAIL read_en c%0d: got %b want %b", c, sram_en, (c <= 2));
      end
      vectors++;
      if (ack0 !== (c == 3) || ack1 !== 1'b0) begin
        miscompares++; $display("FAIL read_ack c%0d: got %b%b want %b0", c, ack0, ack1, (c == 3));
      end
      if (c <= 2) begin
        vectors++;
        if (sram_addr !== 20'h00010 || sram_wen !== 1'b0) begin
          miscompares++; $display("FAIL read_addr c%0d: got %h/%b want 00010/0", c, sram_addr, sram_wen);
        end
      end
      if (c == 3 || c == 5) begin
        vectors++;
        if (rdata0 !== 16'hBEEF) begin
          miscompares++; $display("FAIL read_rdata0 c%0d: got %h want beef", c, rdata0);
        end
      end
      if (c == 3) req0 = 0;
    end
  endtask

  // Continues from the idle state left by test_single_read.
  task automatic test_single_write;
    req1 = 1; wen1 = 1; addr1 = 20'hFFFFF; wdata1 = 16'h1234; sram_rdata = 16'h5A5A;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (sram_en !== (c <= 2) || sram_wen !== (c <= 2)) begin
        miscompares++; $display("FAIL write_en c%0d: got %b%b want %b", c, sram_en, sram_wen, (c <= 2));
      end
      vectors++;
      if (sram_addr !== 20'hFFFFF || sram_wdata !== 16'h1234) begin
        miscompares++; $display("FAIL write_bus c%0d: got %h/%h want fffff/1234", c, sram_addr, sram_wdata);
      end
      vectors++;
      if (ack1 !== (c == 3) || ack0 !== 1'b0) begin
        miscompares++; $display("FAIL write_ack c%0d: got %b%b want 0%b", c, ack0, ack1, (c == 3));
      end
      vectors++;
      if (rdata1 !== 16'h0 || rdata0 !== 16'hBEEF) begin
        miscompares++; $display("FAIL write_rdata c%0d: got %h/%h want beef/0000", c, rdata0, rdata1);
      end
      if (c == 3) req1 = 0;
    end
  endtask

  task automatic test_contention;
    apply_reset();
    req0 = 1; req1 = 1; addr0 = 20'h00001; addr1 = 20'h00002;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (ack0 !== (c == 3 || c == 11) || ack1 !== (c == 7 || c == 15)) begin
        miscompares++; $display("FAIL contention_ack c%0d: got %b%b", c, ack0, ack1);
      end
      if (c == 1 || c == 9) begin
        vectors++;
        if (sram_addr !== 20'h00001) begin
          miscompares++; $display("FAIL contention_grant c%0d: got %h want 00001", c, sram_addr);
        end
      end
      if (c == 5 || c == 13) begin
        vectors++;
        if (sram_addr !== 20'h00002) begin
          miscompares++; $display("FAIL contention_grant c%0d: got %h want 00002", c, sram_addr);
        end
      end
    end
    req0 = 0; req1 = 0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    logic [19:0] exp_addr;
    apply_reset();
    req0 = 1; wen0 = 0; addr0 = 20'h0AAAA; sram_rdata = 16'h1111;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      exp_addr = (c <= 4) ? 20'h0AAAA : 20'h0BBBB;
      vectors++;
      if (sram_addr !== exp_addr) begin
        miscompares++; $display("FAIL b2b_addr c%0d: got %h want %h", c, sram_addr, exp_addr);
      end
      vectors++;
      if (sram_en !== (c == 1 || c == 2 || c == 5 || c == 6)) begin
        miscompares++; $display("FAIL b2b_en c%0d: got %b", c, sram_en);
      end
      vectors++;
      if (ack0 !== (c == 3 || c == 7)) begin
        miscompares++; $display("FAIL b2b_ack c%0d: got %b", c, ack0);
      end
      if (c == 3 || c == 7) begin
        vectors++;
        if (rdata0 !== ((c == 3) ? 16'h1111 : 16'h2222)) begin
          miscompares++; $display("FAIL b2b_rdata c%0d: got %h", c, rdata0);
        end
      end
      if (c == 1) addr0 = 20'h0DEAD;
      if (c == 3) begin addr0 = 20'h0BBBB; sram_rdata = 16'h2222; end
      if (c == 7) req0 = 0;
    end
  endtask

  task automatic test_wait_states;
    apply_reset();
    w3_req0 = 1; w3_wen0 = 0; w3_addr0 = 20'h00123; w3_sram_rdata = 16'h1000;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (w3_sram_en !== (c <= 4)) begin
        miscompares++; $display("FAIL wait3_en c%0d: got %b want %b", c, w3_sram_en, (c <= 4));
      end
      vectors++;
      if (w3_ack0 !== (c == 5) || w3_ack1 !== 1'b0) begin
        miscompares++; $display("FAIL wait3_ack c%0d: got %b%b", c, w3_ack0, w3_ack1);
      end
      vectors++;
      if (w3_busy !== (c <= 5)) begin
        miscompares++; $display("FAIL wait3_busy c%0d: got %b want %b", c, w3_busy, (c <= 5));
      end
      if (c == 5) begin
        vectors++;
        if (w3_rdata0 !== 16'h1004) begin
          miscompares++; $display("FAIL wait3_rdata c%0d: got %h want 1004", c, w3_rdata0);
        end
        w3_req0 = 0;
      end
      w3_sram_rdata = 16'(16'h1000 + c);
    end
  endtask

  task automatic test_mid_reset;
    apply_reset();
    req0 = 1; wen0 = 1; addr0 = 20'h00777; wdata0 = 16'hCAFE;
    @(posedge clk); #1;
    vectors++;
    if (sram_en !== 1'b1 || sram_wen !== 1'b1) begin
      miscompares++; $display("FAIL midrst_started: got %b%b want 11", sram_en, sram_wen);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({sram_en, sram_wen, busy, ack0, ack1} !== 5'b0 || {sram_addr, sram_wdata} !== 36'h0) begin
      miscompares++; $display("FAIL midrst_clear: got %b %h want 0", {sram_en, sram_wen, busy, ack0, ack1},
                              {sram_addr, sram_wdata});
    end
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({ack0, ack1} !== 2'b00) begin
      miscompares++; $display("FAIL midrst_no_ack: got %b want 00", {ack0, ack1});
    end
    rst_n = 1'b1;
    req0 = 1; req1 = 1; addr0 = 20'h00100; addr1 = 20'h00200;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        vectors++;
        if (sram_addr !== 20'h00100) begin
          miscompares++; $display("FAIL midrst_tie_grant: got %h want 00100", sram_addr);
        end
      end
      if (c == 3) begin
        vectors++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
          miscompares++; $display("FAIL midrst_tie_ack: got %b%b want 10", ack0, ack1);
        end
      end
    end
    clear_inputs();
    repeat (4) @(posedge clk);
  endtask

  // Reference model: a grant in cycle g drives the bus in g+1..g+1+W,
  // acks in g+2+W and the arbiter samples requests again from g+3+W.
  task automatic test_random(input int n);
    int          g, free_at, gp;
    logic        gw, lastp;
    logic [19:0] ga;
    logic [15:0] gd, er0, er1, samp;
    logic        e_en, e_busy, e_ack0, e_ack1;
    g = -100; free_at = 0; gp = 0; gw = 0; lastp = 1;
    ga = '0; gd = '0; er0 = '0; er1 = '0; samp = '0;
    e_ack0 = 0; e_ack1 = 0;
    apply_reset();
    for (int cyc = 0; cyc <= n; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        e_en   = (cyc >= g + 1) && (cyc <= g + 1 + WA);
        e_busy = (cyc >= g + 1) && (cyc <= g + 2 + WA);
        e_ack0 = (cyc == g + 2 + WA) && (gp == 0);
        e_ack1 = (cyc == g + 2 + WA) && (gp == 1);
        if (cyc == g + 2 + WA && !gw) begin
          if (gp == 0) er0 = samp;
          else         er1 = samp;
        end
        vectors++;
        if (sram_en !== e_en || sram_wen !== (e_en & gw) || busy !== e_busy) begin
          miscompares++; $display("FAIL rand_ctrl cyc%0d: got en%b wen%b busy%b want en%b wen%b busy%b",
                                  cyc, sram_en, sram_wen, busy, e_en, e_en & gw, e_busy);
        end
        vectors++;
        if (sram_addr !== ga || sram_wdata !== gd) begin
          miscompares++; $display("FAIL rand_bus cyc%0d: got %h/%h want %h/%h", cyc, sram_addr, sram_wdata, ga, gd);
        end
        vectors++;
        if (ack0 !== e_ack0 || ack1 !== e_ack1) begin
          miscompares++; $display("FAIL rand_ack cyc%0d: got %b%b want %b%b", cyc, ack0, ack1, e_ack0, e_ack1);
        end
        vectors++;
        if (rdata0 !== er0 || rdata1 !== er1) begin
          miscompares++; $display("FAIL rand_rdata cyc%0d: got %h/%h want %h/%h", cyc, rdata0, rdata1, er0, er1);
        end
      end
      if (e_ack0) req0 = ($urandom_range(1, 0) == 1);
      else if (!req0 && $urandom_range(3, 0) == 0) req0 = 1;
      if (e_ack1) req1 = ($urandom_range(1, 0) == 1);
      else if (!req1 && $urandom_range(3, 0) == 0) req1 = 1;
      wen0 = ($urandom_range(1, 0) == 1); addr0 = 20'($urandom); wdata0 = 16'($urandom);
      wen1 = ($urandom_range(1, 0) == 1); addr1 = 20'($urandom); wdata1 = 16'($urandom);
      sram_rdata = 16'($urandom);
      if (cyc == g + 1 + WA) samp = sram_rdata;
      if (cyc >= free_at && (req0 || req1)) begin
        if (req0 && req1) gp = lastp ? 0 : 1;
        else              gp = req1 ? 1 : 0;
        lastp   = (gp == 1);
        g       = cyc;
        free_at = cyc + 3 + WA;
        gw      = (gp == 1) ? wen1 : wen0;
        ga      = (gp == 1) ? addr1 : addr0;
        gd      = (gp == 1) ? wdata1 : wdata0;
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_wait_states();
    test_mid_reset();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
